// File: rtl/store_sequence_checker.sv
// Data-memory store monitor: checks core stores against an ordered table of
// expected (address, data) pairs, tolerating stores into a scratch window.
module store_sequence_checker #(
  parameter int          AW       = 32,
  parameter int          DW       = 32,
  parameter int          DEPTH    = 4,
  parameter int          TIMEOUT  = 1024,
  parameter logic [AW-1:0] IGN_BASE = 96,
  parameter logic [AW-1:0] IGN_MASK = '1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         MemWrite,
  input  logic [AW-1:0]                DataAdr,
  input  logic [DW-1:0]                WriteData,
  input  logic                         cfg_we,
  input  logic [$clog2(DEPTH)-1:0]     cfg_idx,
  input  logic [AW-1:0]                cfg_adr,
  input  logic [DW-1:0]                cfg_data,
  input  logic                         cfg_count_we,
  input  logic [$clog2(DEPTH+1)-1:0]   cfg_count,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [1:0]                   fail_code,
  output logic [$clog2(DEPTH+1)-1:0]   match_cnt,
  output logic [15:0]                  ign_cnt,
  output logic [AW-1:0]                fail_adr,
  output logic [DW-1:0]                fail_data
);
  localparam int IW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH+1);
  localparam int TW   = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  typedef struct packed {
    logic [AW-1:0] adr;
    logic [DW-1:0] data;
  } entry_t;

  state_t          state, state_d;
  entry_t          tbl [DEPTH];
  entry_t          cur;
  logic [CNTW-1:0] cnt;
  logic [TW-1:0]   cyc;
  logic            hit, ign, mis, tmo;

  // Table and active count are frozen while a check is running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
      cnt <= '0;
    end else if (state != S_RUN) begin
      if (cfg_we)
        for (int i = 0; i < DEPTH; i++)
          if (cfg_idx == IW'(i)) tbl[i] <= '{adr: cfg_adr, data: cfg_data};
      if (cfg_count_we)
        cnt <= (cfg_count > CNTW'(DEPTH)) ? CNTW'(DEPTH) : cfg_count;
    end
  end

  // match_cnt doubles as the pointer to the next expected entry.
  always_comb begin
    cur = '0;
    for (int i = 0; i < DEPTH; i++)
      if (match_cnt == CNTW'(i)) cur = tbl[i];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    hit     = 1'b0;
    ign     = 1'b0;
    mis     = 1'b0;
    tmo     = 1'b0;
    if (state == S_RUN) begin
      if (cnt == '0) begin
        state_d = S_PASS;
      end else begin
        if (MemWrite) begin
          if (DataAdr == cur.adr && WriteData == cur.data) begin
            hit = 1'b1;
            if ((match_cnt + CNTW'(1)) == cnt) state_d = S_PASS;
          end else if ((DataAdr & IGN_MASK) == (IGN_BASE & IGN_MASK)) begin
            ign = 1'b1;
          end else begin
            mis     = 1'b1;
            state_d = S_FAIL;
          end
        end
        // A final match wins over a timeout on the same edge.
        if (state_d == S_RUN && cyc == TW'(TIMEOUT-1)) begin
          tmo     = 1'b1;
          state_d = S_FAIL;
        end
      end
    end
    if (start) state_d = S_RUN;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_cnt <= '0;
      ign_cnt   <= '0;
      cyc       <= '0;
      fail_code <= '0;
      fail_adr  <= '0;
      fail_data <= '0;
    end else if (start) begin
      match_cnt <= '0;
      ign_cnt   <= '0;
      cyc       <= '0;
      fail_code <= '0;
      fail_adr  <= '0;
      fail_data <= '0;
    end else if (state == S_RUN) begin
      cyc <= cyc + TW'(1);
      if (hit) match_cnt <= match_cnt + CNTW'(1);
      if (ign && ign_cnt != 16'hFFFF) ign_cnt <= ign_cnt + 16'd1;
      if (mis) begin
        fail_code <= 2'd1;
        fail_adr  <= DataAdr;
        fail_data <= WriteData;
      end else if (tmo) begin
        fail_code <= 2'd2;
      end
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_PASS) || (state == S_FAIL);
  assign pass = (state == S_PASS);

endmodule

// File: tb/tb_store_sequence_checker.sv
// Bench for store_sequence_checker: directed scenarios plus randomized runs
// scored against a per-run outcome model derived from the store rules.
module tb_store_sequence_checker;
  localparam int AW = 32, DW = 32, DEPTH = 4, TMO = 16, NCYC = 20;

  logic          clk = 0, reset = 1;
  logic          MemWrite = 0;
  logic [AW-1:0] DataAdr = '0;
  logic [DW-1:0] WriteData = '0;
  logic          cfg_we = 0;
  logic [1:0]    cfg_idx = '0;
  logic [AW-1:0] cfg_adr = '0;
  logic [DW-1:0] cfg_data = '0;
  logic          cfg_count_we = 0;
  logic [2:0]    cfg_count = '0;
  logic          start = 0;
  logic          busy, done, pass;
  logic [1:0]    fail_code;
  logic [2:0]    match_cnt;
  logic [15:0]   ign_cnt;
  logic [AW-1:0] fail_adr;
  logic [DW-1:0] fail_data;

  store_sequence_checker #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .TIMEOUT(TMO),
                           .IGN_BASE(96), .IGN_MASK('1)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_adr(cfg_adr), .cfg_data(cfg_data), .cfg_count_we(cfg_count_we),
    .cfg_count(cfg_count), .start(start), .busy(busy), .done(done),
    .pass(pass), .fail_code(fail_code), .match_cnt(match_cnt),
    .ign_cnt(ign_cnt), .fail_adr(fail_adr), .fail_data(fail_data));

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic cfg_entry(input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cfg_we = 1; cfg_idx = idx[1:0]; cfg_adr = a; cfg_data = d;
    tick();
    cfg_we = 0;
  endtask

  task automatic cfg_cnt(input int c);
    cfg_count_we = 1; cfg_count = c[2:0];
    tick();
    cfg_count_we = 0;
  endtask

  task automatic do_start();
    start = 1; tick(); start = 0;
  endtask

  task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d);
    MemWrite = 1; DataAdr = a; WriteData = d;
    tick();
    MemWrite = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_all(input string tag, input logic b, input logic dn, input logic p,
                         input int code, input int mc, input int ic, input int fa, input int fd);
    chk({tag, ".busy"}, 64'(busy), 64'(b));
    chk({tag, ".done"}, 64'(done), 64'(dn));
    chk({tag, ".pass"}, 64'(pass), 64'(p));
    chk({tag, ".code"}, 64'(fail_code), 64'(code));
    chk({tag, ".match"}, 64'(match_cnt), 64'(mc));
    chk({tag, ".ign"}, 64'(ign_cnt), 64'(ic));
    chk({tag, ".fadr"}, 64'(fail_adr), 64'(fa));
    chk({tag, ".fdata"}, 64'(fail_data), 64'(fd));
  endtask

  // Random-run model: outcome of a run computed from the ordered-table rules.
  int tadr[DEPTH], tdat[DEPTH];
  int pool[5] = '{96, 100, 104, 108, 200};
  int d_we[NCYC+1], d_adr[NCYC+1], d_dat[NCYC+1];
  int e_st[NCYC+1], e_code[NCYC+1], e_mc[NCYC+1], e_ic[NCYC+1], e_fa[NCYC+1], e_fd[NCYC+1];

  task automatic build_run(input int active);
    int ptr, ig, st, code, fa, fd, r;
    ptr = 0; ig = 0; st = 0; code = 0; fa = 0; fd = 0;
    for (int j = 1; j <= NCYC; j++) begin
      r = $urandom_range(0, 9);
      d_we[j] = (r >= 2) ? 1 : 0;
      d_adr[j] = pool[$urandom_range(0, 4)];
      d_dat[j] = $urandom_range(0, 3);
      if (r >= 2 && r <= 5 && ptr < active) begin
        d_adr[j] = tadr[ptr]; d_dat[j] = tdat[ptr];
      end else if (r == 6 || r == 7) begin
        d_adr[j] = 96;
      end
      if (st == 0) begin
        if (active == 0) st = 1;
        else begin
          if (d_we[j] == 1) begin
            if (d_adr[j] == tadr[ptr] && d_dat[j] == tdat[ptr]) begin
              ptr++;
              if (ptr == active) st = 1;
            end else if (d_adr[j] == 96) ig++;
            else begin st = 2; code = 1; fa = d_adr[j]; fd = d_dat[j]; end
          end
          if (st == 0 && j == TMO) begin st = 2; code = 2; end
        end
      end
      e_st[j] = st; e_code[j] = code; e_mc[j] = ptr; e_ic[j] = ig; e_fa[j] = fa; e_fd[j] = fd;
    end
  endtask

  task automatic rand_run();
    int c, active;
    c = $urandom_range(0, 7);
    active = (c > DEPTH) ? DEPTH : c;
    for (int i = 0; i < DEPTH; i++) begin
      tadr[i] = pool[$urandom_range(0, 4)];
      tdat[i] = $urandom_range(0, 3);
      cfg_entry(i, tadr[i], tdat[i]);
    end
    cfg_cnt(c);
    build_run(active);
    do_start();
    chk_all("rnd.start", 1, 0, 0, 0, 0, 0, 0, 0);
    for (int j = 1; j <= NCYC; j++) begin
      MemWrite = d_we[j][0]; DataAdr = d_adr[j]; WriteData = d_dat[j];
      tick();
      MemWrite = 0;
      chk_all("rnd", e_st[j] == 0, e_st[j] != 0, e_st[j] == 1,
              e_code[j], e_mc[j], e_ic[j], e_fa[j], e_fd[j]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(2);
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); reset = 0;
    tick();

    // scratch stores tolerated, then single expected store passes
    cfg_entry(0, 100, 25); cfg_cnt(1);
    do_start();
    chk_all("t1.run", 1, 0, 0, 0, 0, 0, 0, 0);
    store(96, 7); store(96, 9);
    chk_all("t1.ign", 1, 0, 0, 0, 0, 2, 0, 0);
    store(100, 25);
    chk_all("t1.pass", 0, 1, 1, 0, 1, 2, 0, 0);

    // wrong data fails and the result then holds
    do_start();
    store(100, 24);
    chk_all("t2.fail", 0, 1, 0, 1, 0, 0, 100, 24);
    store(100, 25); store(104, 9);
    chk_all("t2.hold", 0, 1, 0, 1, 0, 0, 100, 24);

    // three in order, then out of order after restart
    cfg_entry(0, 100, 1); cfg_entry(1, 104, 2); cfg_entry(2, 108, 3); cfg_cnt(3);
    do_start();
    store(100, 1); store(104, 2);
    chk_all("t3.mid", 1, 0, 0, 0, 2, 0, 0, 0);
    store(108, 3);
    chk_all("t3.pass", 0, 1, 1, 0, 3, 0, 0, 0);
    do_start();
    store(104, 2);
    chk_all("t3.order", 0, 1, 0, 1, 0, 0, 104, 2);

    // timeout exactly TMO cycles after start edge
    do_start();
    idle(TMO-1);
    chk_all("t4.pre", 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk_all("t4.tmo", 0, 1, 0, 2, 0, 0, 0, 0);
    // final match on the timeout edge wins
    do_start();
    store(100, 1); store(104, 2);
    idle(TMO-3);
    store(108, 3);
    chk_all("t4.last", 0, 1, 1, 0, 3, 0, 0, 0);

    // asynchronous reset mid-run
    do_start();
    store(100, 1);
    chk_all("t5.mid", 1, 0, 0, 0, 1, 0, 0, 0);
    #2 reset = 1;
    #1 chk_all("t5.async", 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); reset = 0;
    tick();
    chk_all("t5.idle", 0, 0, 0, 0, 0, 0, 0, 0);
    do_start();
    chk("t5.busy0", 64'(busy), 64'(1));
    tick();
    chk_all("t5.cnt0", 0, 1, 1, 0, 0, 0, 0, 0);
    cfg_cnt(1);
    do_start();
    store(0, 0);
    chk_all("t5.zero", 0, 1, 1, 0, 1, 0, 0, 0);

    // cfg write during RUN dropped; after completion accepted
    cfg_entry(0, 100, 25);
    do_start();
    cfg_entry(0, 200, 5);
    store(100, 25);
    chk_all("t6.old", 0, 1, 1, 0, 1, 0, 0, 0);
    cfg_entry(0, 200, 5);
    do_start();
    store(200, 5);
    chk_all("t6.new", 0, 1, 1, 0, 1, 0, 0, 0);

    for (int r = 0; r < 40; r++) rand_run();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
